// File: rtl/probe_scheduler_pkg.sv
// Shared types and constants for the rtt_probe launch scheduler.
// FSM encodings, minimum probe length, LFSR seed/taps, word-count helper.
package probe_scheduler_pkg;

    typedef enum logic [2:0] {
        PS_IDLE   = 3'd0,
        PS_ARM    = 3'd1,
        PS_REQ    = 3'd2,
        PS_ACTIVE = 3'd3
    } ps_state_e;

    localparam int unsigned PS_MIN_LEN = 60;

    // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
    localparam logic [15:0] PS_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] PS_LFSR_TAPS = 16'hB400;

    // ceil(len/8), 13-bit result
    function automatic logic [12:0] ps_words(input logic [15:0] len);
        return 13'(({1'b0, len} + 17'd7) >> 3);
    endfunction

endpackage

// File: rtl/probe_scheduler_lfsr.sv
// 16-bit Fibonacci LFSR used to jitter the probe slot timer.
// Ports: clk, reset (async active-low), step_i advances, state_o current value.
module probe_lfsr16
    import probe_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (step_i) begin
            state_d = {state_q[14:0], ^(state_q & PS_LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PS_LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/probe_scheduler.sv
// Paces probe launches into the rtt_probe generator; stamps length/sequence.
// Ports: cfg_* from register block, pass_busy defers launches, gen_* handshake,
// sent_cnt/overrun_cnt/sched_state status. Macro PROBE_SCHED_JITTER_EN adds
// cfg_jitter_mask and an LFSR-jittered slot reload.
module probe_scheduler
    import probe_scheduler_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = 32,
    parameter int unsigned SEQ_WIDTH    = 32,
    parameter int unsigned MIN_LEN      = PS_MIN_LEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_enable,
    input  logic                    cfg_trigger,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    input  logic [15:0]             cfg_burst,
    input  logic [15:0]             cfg_len,
    input  logic                    pass_busy,
    output logic                    gen_req,
    input  logic                    gen_ack,
    input  logic                    gen_done,
    output logic [15:0]             gen_len,
    output logic [12:0]             gen_words,
    output logic [SEQ_WIDTH-1:0]    gen_seq,
    output logic [31:0]             sent_cnt,
    output logic [15:0]             overrun_cnt,
    output logic [2:0]              sched_state
`ifdef PROBE_SCHED_JITTER_EN
    ,
    input  logic [15:0]             cfg_jitter_mask
`endif
);

    localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);

    ps_state_e               state_q, state_d;
    logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
    logic [PERIOD_WIDTH-1:0] wait_q, wait_d;
    logic [15:0]             remaining_q, remaining_d;
    logic                    burst_q, burst_d;
    logic                    missed_q, missed_d;
    logic                    req_q, req_d;
    logic [15:0]             len_q, len_d;
    logic [12:0]             words_q, words_d;
    logic [SEQ_WIDTH-1:0]    seq_q, seq_d;
    logic [31:0]             sent_q, sent_d;
    logic [15:0]             ovr_q, ovr_d;

    logic [PERIOD_WIDTH-1:0] per_m1;
    logic [PERIOD_WIDTH-1:0] reload;
    logic [PERIOD_WIDTH-1:0] timer_dec;
    logic [15:0]             len_clamp;
    logic [15:0]             ovr_inc;
    logic                    slot_open;

    assign per_m1    = (cfg_period == '0) ? '0
                                          : cfg_period - PERIOD_WIDTH'(1);
    assign timer_dec = (timer_q == '0) ? '0 : timer_q - PERIOD_WIDTH'(1);
    assign len_clamp = (cfg_len < MIN_LEN16) ? MIN_LEN16 : cfg_len;
    assign ovr_inc   = (ovr_q == 16'hFFFF) ? ovr_q : ovr_q + 16'd1;

    // Request one cycle before the timer expires so the registered
    // gen_req meets an instant ack exactly one period after the last ack.
    assign slot_open = (timer_q <= PERIOD_WIDTH'(1));

`ifdef PROBE_SCHED_JITTER_EN
    logic [15:0] lfsr;
    logic        lfsr_step;

    assign lfsr_step = (state_q == PS_REQ) && gen_ack;

    probe_lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .step_i  (lfsr_step),
        .state_o (lfsr)
    );

    assign reload = per_m1 + PERIOD_WIDTH'(lfsr & cfg_jitter_mask);
`else
    assign reload = per_m1;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_dec;
        wait_d      = '0;
        remaining_d = remaining_q;
        burst_d     = burst_q;
        missed_d    = missed_q;
        req_d       = req_q;
        len_d       = len_q;
        words_d     = words_q;
        seq_d       = seq_q;
        sent_d      = sent_q;
        ovr_d       = ovr_q;
        unique case (state_q)
            PS_IDLE: begin
                if (cfg_enable && cfg_burst == 16'd0) begin
                    state_d = PS_ARM;
                    burst_d = 1'b0;
                end else if (cfg_enable && cfg_trigger) begin
                    state_d     = PS_ARM;
                    burst_d     = 1'b1;
                    remaining_d = cfg_burst;
                end
            end
            PS_ARM: begin
                if (!cfg_enable) begin
                    state_d = PS_IDLE;
                end else if (slot_open && !pass_busy) begin
                    state_d = PS_REQ;
                    req_d   = 1'b1;
                    len_d   = len_clamp;
                    words_d = ps_words(len_clamp);
                end else if (timer_q == '0) begin
                    // Blocked by pass-through: one overrun per lost period.
                    if (wait_q == per_m1) begin
                        ovr_d = ovr_inc;
                    end else begin
                        wait_d = wait_q + PERIOD_WIDTH'(1);
                    end
                end
            end
            PS_REQ: begin
                if (gen_ack) begin
                    state_d  = PS_ACTIVE;
                    req_d    = 1'b0;
                    timer_d  = reload;
                    missed_d = 1'b0;
                end
            end
            PS_ACTIVE: begin
                if (gen_done) begin
                    sent_d = sent_q + 32'd1;
                    seq_d  = seq_q + SEQ_WIDTH'(1);
                    if (burst_q) begin
                        remaining_d = remaining_q - 16'd1;
                    end
                    if (!cfg_enable || (burst_q && remaining_q == 16'd1)) begin
                        state_d = PS_IDLE;
                    end else begin
                        state_d = PS_ARM;
                    end
                end else if (timer_q == '0 && !missed_q) begin
                    ovr_d    = ovr_inc;
                    missed_d = 1'b1;
                end
            end
            default: state_d = PS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PS_IDLE;
            timer_q     <= '0;
            wait_q      <= '0;
            remaining_q <= '0;
            burst_q     <= 1'b0;
            missed_q    <= 1'b0;
            req_q       <= 1'b0;
            len_q       <= '0;
            words_q     <= '0;
            seq_q       <= '0;
            sent_q      <= '0;
            ovr_q       <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            wait_q      <= wait_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            missed_q    <= missed_d;
            req_q       <= req_d;
            len_q       <= len_d;
            words_q     <= words_d;
            seq_q       <= seq_d;
            sent_q      <= sent_d;
            ovr_q       <= ovr_d;
        end
    end

    assign gen_req     = req_q;
    assign gen_len     = len_q;
    assign gen_words   = words_q;
    assign gen_seq     = seq_q;
    assign sent_cnt    = sent_q;
    assign overrun_cnt = ovr_q;
    assign sched_state = state_q;

endmodule

// File: tb/tb_probe_scheduler.sv
// Self-checking bench for probe_scheduler: randomised scenarios vs spec model.
// Generator is emulated: ack follows gen_req when ack_en, done a set delay later.
module tb_probe_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_enable;
    logic        cfg_trigger;
    logic [31:0] cfg_period;
    logic [15:0] cfg_burst;
    logic [15:0] cfg_len;
    logic        pass_busy;
    logic        gen_req;
    logic        gen_ack;
    logic        gen_done;
    logic [15:0] gen_len;
    logic [12:0] gen_words;
    logic [31:0] gen_seq;
    logic [31:0] sent_cnt;
    logic [15:0] overrun_cnt;
    logic [2:0]  sched_state;
`ifdef PROBE_SCHED_JITTER_EN
    logic [15:0] cfg_jitter_mask;
`endif

    logic ack_en;
    logic gen_flush;
    int   done_delay;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ack_cyc[$];
    int   done_cyc[$];
    int   pend = 0;
    int   handled = 0;

    assign gen_ack = gen_req & ack_en;

    always #5 clk = ~clk;

    probe_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_enable  (cfg_enable),
        .cfg_trigger (cfg_trigger),
        .cfg_period  (cfg_period),
        .cfg_burst   (cfg_burst),
        .cfg_len     (cfg_len),
        .pass_busy   (pass_busy),
        .gen_req     (gen_req),
        .gen_ack     (gen_ack),
        .gen_done    (gen_done),
        .gen_len     (gen_len),
        .gen_words   (gen_words),
        .gen_seq     (gen_seq),
        .sent_cnt    (sent_cnt),
        .overrun_cnt (overrun_cnt),
        .sched_state (sched_state)
`ifdef PROBE_SCHED_JITTER_EN
        ,
        .cfg_jitter_mask (cfg_jitter_mask)
`endif
    );

    // Event log of handshakes, sampled at the active edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (gen_ack) ack_cyc.push_back(cyc);
        if (gen_done) done_cyc.push_back(cyc);
    end

    // Generator model: gen_done sampled done_delay edges after the ack edge.
    always @(negedge clk) begin
        gen_done = 1'b0;
        if (gen_flush) begin
            pend = 0;
            handled = ack_cyc.size();
        end else begin
            if (ack_cyc.size() > handled) begin
                handled = ack_cyc.size();
                pend = done_delay;
            end
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) gen_done = 1'b1;
            end
        end
    end

    task automatic do_reset();
        gen_flush = 1'b1;
        cfg_enable = 1'b0;
        cfg_trigger = 1'b0;
        pass_busy = 1'b0;
        ack_en = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        gen_flush = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (gen_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (sched_state == 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        gen_flush = 1'b1;
        reset = 1'b1;
        #3 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gen_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset gen_req: got %0b want 0", gen_req);
        end
        n_checks++;
        if (gen_len !== 16'd0 || gen_words !== 13'd0) begin
            n_fail++;
            $display("FAIL reset len/words: got %0d/%0d want 0/0", gen_len, gen_words);
        end
        n_checks++;
        if (gen_seq !== 32'd0 || sent_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset seq/sent: got %0d/%0d want 0/0", gen_seq, sent_cnt);
        end
        n_checks++;
        if (overrun_cnt !== 16'd0 || sched_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset ovr/state: got %0d/%0d want 0/0", overrun_cnt, sched_state);
        end
        do_reset();
    endtask

    task automatic test_periodic(input int period, input int d, input int n);
        bit ok;
        int base;
        do_reset();
        cfg_burst = 16'd0;
        cfg_period = 32'(period);
        cfg_len = 16'd64;
        done_delay = d;
        base = ack_cyc.size();
        cfg_enable = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_req(3 * period + 20, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL periodic req timeout: probe %0d of %0d", k, n);
                break;
            end
            n_checks++;
            if (gen_seq !== 32'(k)) begin
                n_fail++;
                $display("FAIL periodic seq: got %0d want %0d", gen_seq, k);
            end
        end
        cfg_enable = 1'b0;
        wait_idle(3 * period + 40, ok);
        n_checks++;
        if (!ok || ack_cyc.size() != base + n) begin
            n_fail++;
            $display("FAIL periodic acks: got %0d want %0d", ack_cyc.size() - base, n);
        end else begin
            for (int k = 1; k < n; k++) begin
                n_checks++;
                if (ack_cyc[base + k] - ack_cyc[base + k - 1] != period) begin
                    n_fail++;
                    $display("FAIL periodic spacing: got %0d want %0d",
                             ack_cyc[base + k] - ack_cyc[base + k - 1], period);
                end
            end
        end
        n_checks++;
        if (overrun_cnt !== 16'd0 || sent_cnt !== 32'(n) || gen_seq !== 32'(n)) begin
            n_fail++;
            $display("FAIL periodic ovr/sent/seq: got %0d/%0d/%0d want 0/%0d/%0d",
                     overrun_cnt, sent_cnt, gen_seq, n, n);
        end
    endtask

    task automatic test_burst(input int nb);
        bit ok;
        int base;
        do_reset();
        cfg_burst = 16'(nb);
        cfg_period = 32'd20;
        cfg_len = 16'd100;
        done_delay = 5;
        base = ack_cyc.size();
        cfg_enable = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (sched_state !== 3'd0 || ack_cyc.size() != base) begin
            n_fail++;
            $display("FAIL burst no-trigger idle: got state %0d want 0", sched_state);
        end
        cfg_trigger = 1'b1;
        @(negedge clk);
        cfg_trigger = 1'b0;
        wait_req(60, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL burst first req timeout: got none want 1");
        end
        @(negedge clk);
        cfg_trigger = 1'b1;
        @(negedge clk);
        cfg_trigger = 1'b0;
        wait_idle(40 * nb + 100, ok);
        repeat (60) @(negedge clk);
        n_checks++;
        if (!ok || ack_cyc.size() - base != nb) begin
            n_fail++;
            $display("FAIL burst probes: got %0d want %0d", ack_cyc.size() - base, nb);
        end
        n_checks++;
        if (sent_cnt !== 32'(nb) || sched_state !== 3'd0) begin
            n_fail++;
            $display("FAIL burst sent/state: got %0d/%0d want %0d/0", sent_cnt, sched_state, nb);
        end
        cfg_enable = 1'b0;
    endtask

    task automatic test_len(input int l);
        bit ok;
        int exp_len;
        int exp_words;
        exp_len = (l < 60) ? 60 : l;
        exp_words = exp_len / 8 + ((exp_len % 8 != 0) ? 1 : 0);
        cfg_len = 16'(l);
        ack_en = 1'b0;
        cfg_trigger = 1'b1;
        @(negedge clk);
        cfg_trigger = 1'b0;
        wait_req(40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL len req timeout: len %0d", l);
        end
        n_checks++;
        if (gen_len !== 16'(exp_len) || gen_words !== 13'(exp_words)) begin
            n_fail++;
            $display("FAIL len clamp %0d: got %0d/%0d want %0d/%0d",
                     l, gen_len, gen_words, exp_len, exp_words);
        end
        cfg_len = 16'($urandom_range(0, 65520));
        @(negedge clk);
        n_checks++;
        if (gen_len !== 16'(exp_len)) begin
            n_fail++;
            $display("FAIL len in-flight: got %0d want %0d", gen_len, exp_len);
        end
        ack_en = 1'b1;
        @(negedge clk);
        ack_en = 1'b0;
        wait_idle(40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL len idle timeout: state %0d want 0", sched_state);
        end
    endtask

    task automatic test_lengths();
        int fixed_len[6];
        fixed_len = '{10, 1500, 59, 60, 61, 0};
        do_reset();
        cfg_burst = 16'd1;
        cfg_period = 32'd4;
        done_delay = 3;
        cfg_enable = 1'b1;
        foreach (fixed_len[i]) test_len(fixed_len[i]);
        for (int i = 0; i < 6; i++) test_len(int'($urandom_range(0, 65520)));
        ack_en = 1'b1;
        cfg_enable = 1'b0;
    endtask

    task automatic test_pass_busy(input int hold);
        bit ok;
        int bad;
        int period;
        period = 100;
        do_reset();
        cfg_burst = 16'd0;
        cfg_period = 32'(period);
        cfg_len = 16'd64;
        done_delay = 10;
        pass_busy = 1'b1;
        cfg_enable = 1'b1;
        bad = 0;
        for (int t = 0; t < hold; t++) begin
            @(negedge clk);
            if (gen_req !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL busy hold req: got %0d req cycles want 0", bad);
        end
        // IDLE->ARM takes the first held cycle; the rest are blocked slots.
        n_checks++;
        if (overrun_cnt !== 16'((hold - 1) / period)) begin
            n_fail++;
            $display("FAIL busy overrun hold %0d: got %0d want %0d",
                     hold, overrun_cnt, (hold - 1) / period);
        end
        pass_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gen_req !== 1'b1) begin
            n_fail++;
            $display("FAIL busy release latency: got req %0b want 1", gen_req);
        end
        cfg_enable = 1'b0;
        wait_idle(60, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL busy idle timeout: state %0d want 0", sched_state);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int bad;
        int base;
        do_reset();
        cfg_burst = 16'd0;
        cfg_period = 32'd30;
        cfg_len = 16'd80;
        done_delay = 6;
        ack_en = 1'b0;
        base = ack_cyc.size();
        cfg_enable = 1'b1;
        wait_req(20, ok);
        cfg_enable = 1'b0;
        bad = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (gen_req !== 1'b1 || sched_state !== 3'd2) bad++;
        end
        n_checks++;
        if (!ok || bad != 0) begin
            n_fail++;
            $display("FAIL drop req held: got %0d bad cycles want 0", bad);
        end
        ack_en = 1'b1;
        @(negedge clk);
        ack_en = 1'b0;
        n_checks++;
        if (gen_req !== 1'b0 || sched_state !== 3'd3) begin
            n_fail++;
            $display("FAIL drop after ack: got req %0b state %0d want 0/3", gen_req, sched_state);
        end
        wait_idle(40, ok);
        repeat (60) @(negedge clk);
        n_checks++;
        if (!ok || sent_cnt !== 32'd1 || gen_seq !== 32'd1 || ack_cyc.size() != base + 1) begin
            n_fail++;
            $display("FAIL drop completion: got sent %0d seq %0d acks %0d want 1/1/1",
                     sent_cnt, gen_seq, ack_cyc.size() - base);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_back_to_back(input int n);
        bit ok;
        int ab;
        int db;
        do_reset();
        cfg_burst = 16'd0;
        cfg_period = 32'd5;
        cfg_len = 16'd120;
        done_delay = 12;
        ab = ack_cyc.size();
        db = done_cyc.size();
        cfg_enable = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_req(60, ok);
            if (!ok) break;
        end
        cfg_enable = 1'b0;
        wait_idle(60, ok);
        n_checks++;
        if (!ok || ack_cyc.size() != ab + n || done_cyc.size() != db + n) begin
            n_fail++;
            $display("FAIL b2b count: got %0d acks want %0d", ack_cyc.size() - ab, n);
        end else begin
            // done edge -> req next edge -> instant ack the edge after
            for (int k = 0; k < n - 1; k++) begin
                n_checks++;
                if (ack_cyc[ab + k + 1] - done_cyc[db + k] != 2) begin
                    n_fail++;
                    $display("FAIL b2b gap: got %0d want 2",
                             ack_cyc[ab + k + 1] - done_cyc[db + k]);
                end
            end
        end
        n_checks++;
        if (overrun_cnt !== 16'(n)) begin
            n_fail++;
            $display("FAIL b2b overrun: got %0d want %0d", overrun_cnt, n);
        end
    endtask

    task automatic test_reset_active();
        bit ok;
        do_reset();
        cfg_burst = 16'd0;
        cfg_period = 32'd40;
        cfg_len = 16'd200;
        done_delay = 8;
        cfg_enable = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sent_cnt == 32'd1 && sched_state == 3'd3) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok || gen_len !== 16'd200) begin
            n_fail++;
            $display("FAIL rst-active setup: got state %0d len %0d want 3/200", sched_state, gen_len);
        end
        #1;
        gen_flush = 1'b1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({gen_req, gen_len, gen_words, gen_seq, sent_cnt, overrun_cnt, sched_state} !== '0) begin
            n_fail++;
            $display("FAIL rst-active outputs: got req %0b len %0d seq %0d sent %0d state %0d want 0",
                     gen_req, gen_len, gen_seq, sent_cnt, sched_state);
        end
        cfg_enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        gen_flush = 1'b0;
    endtask

`ifdef PROBE_SCHED_JITTER_EN
    task automatic test_jitter(input int n);
        bit ok;
        int base;
        int gap;
        do_reset();
        cfg_jitter_mask = 16'h000F;
        cfg_burst = 16'd0;
        cfg_period = 32'd50;
        cfg_len = 16'd64;
        done_delay = 10;
        base = ack_cyc.size();
        cfg_enable = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_req(120, ok);
            if (!ok) break;
        end
        cfg_enable = 1'b0;
        wait_idle(120, ok);
        n_checks++;
        if (ack_cyc.size() != base + n) begin
            n_fail++;
            $display("FAIL jitter acks: got %0d want %0d", ack_cyc.size() - base, n);
        end else begin
            for (int k = 1; k < n; k++) begin
                gap = ack_cyc[base + k] - ack_cyc[base + k - 1];
                n_checks++;
                if (gap < 50 || gap > 65) begin
                    n_fail++;
                    $display("FAIL jitter gap: got %0d want 50..65", gap);
                end
            end
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        gen_flush = 1'b1;
        cfg_enable = 1'b0;
        cfg_trigger = 1'b0;
        cfg_period = 32'd0;
        cfg_burst = 16'd0;
        cfg_len = 16'd0;
        pass_busy = 1'b0;
        ack_en = 1'b1;
        done_delay = 10;
`ifdef PROBE_SCHED_JITTER_EN
        cfg_jitter_mask = 16'd0;
`endif
        test_reset();
        test_periodic(100, 10, 5);
        for (int r = 0; r < 2; r++) begin
            int p;
            p = int'($urandom_range(20, 60));
            test_periodic(p, int'($urandom_range(3, p - 3)), 4);
        end
        test_burst(3);
        test_burst(int'($urandom_range(1, 6)));
        test_lengths();
        test_pass_busy(250);
        test_pass_busy(int'($urandom_range(105, 395)));
        test_enable_drop();
        test_back_to_back(4);
        test_reset_active();
`ifdef PROBE_SCHED_JITTER_EN
        test_jitter(9);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
